urv_writeback: RTL and testbench

- Final (W) pipeline stage of the uRV core. Sits directly downstream of the execute stage and the divider, and consumes their results.
- Selects the rd value from one of three sources:
  - execute-stage ALU/shift/CSR result;
  - divider result register;
  - data-memory load data, after alignment and sign/zero extension.
- Drives the register-file write port.
- Stalls the pipeline while a load is outstanding, with an optional load timeout.

---
 rtl/urv_writeback_pkg.sv | 25 ++
 rtl/urv_writeback_if.sv | 34 +++
 rtl/urv_load_align.sv | 38 +++
 rtl/urv_writeback.sv | 108 ++++++++++
 tb/tb_urv_writeback.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/urv_writeback_pkg.sv
// Shared definitions for the uRV writeback stage: result sources, load/divide
// funct3 codes and the writeback FSM state type.
package urv_writeback_pkg;

  localparam logic [1:0] RD_SOURCE_ALU  = 2'd0;
  localparam logic [1:0] RD_SOURCE_DIV  = 2'd1;
  localparam logic [1:0] RD_SOURCE_LOAD = 2'd2;

  localparam logic [2:0] FUNC_LB   = 3'b000;
  localparam logic [2:0] FUNC_LH   = 3'b001;
  localparam logic [2:0] FUNC_LW   = 3'b010;
  localparam logic [2:0] FUNC_LBU  = 3'b100;
  localparam logic [2:0] FUNC_LHU  = 3'b101;

  localparam logic [2:0] FUNC_DIV  = 3'b100;
  localparam logic [2:0] FUNC_DIVU = 3'b101;
  localparam logic [2:0] FUNC_REM  = 3'b110;
  localparam logic [2:0] FUNC_REMU = 3'b111;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/urv_writeback_if.sv
// Execute/memory-to-writeback bundle. The slave modport is the writeback stage,
// the master modport is its environment (execute stage, memory, register file).
interface urv_writeback_if;
  logic        x_valid_i;
  logic        x_stall_i;
  logic [4:0]  x_rd_i;
  logic        x_rd_write_i;
  logic [1:0]  x_rd_source_i;
  logic [31:0] x_rd_value_i;
  logic [31:0] x_div_result_i;
  logic [2:0]  x_load_fun_i;
  logic [1:0]  x_dm_addr_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_write_o;
  logic        w_stall_req_o;
  logic        w_load_timeout_o;

  modport master (
    output x_valid_i, x_stall_i, x_rd_i, x_rd_write_i, x_rd_source_i,
           x_rd_value_i, x_div_result_i, x_load_fun_i, x_dm_addr_i,
           dm_data_l_i, dm_load_done_i,
    input  rf_rd_o, rf_rd_value_o, rf_rd_write_o, w_stall_req_o, w_load_timeout_o
  );

  modport slave (
    input  x_valid_i, x_stall_i, x_rd_i, x_rd_write_i, x_rd_source_i,
           x_rd_value_i, x_div_result_i, x_load_fun_i, x_dm_addr_i,
           dm_data_l_i, dm_load_done_i,
    output rf_rd_o, rf_rd_value_o, rf_rd_write_o, w_stall_req_o, w_load_timeout_o
  );
endinterface

// File: rtl/urv_load_align.sv
// Load data alignment and sign/zero extension; shared with the load bypass path.
module urv_load_align
  import urv_writeback_pkg::*;
(
  input  logic [2:0]  fun_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension according to the load type.
  always_comb begin
    case (addr_i)
      2'd0:    byte_s = data_i[7:0];
      2'd1:    byte_s = data_i[15:8];
      2'd2:    byte_s = data_i[23:16];
      default: byte_s = data_i[31:24];
    endcase

    if (addr_i[1]) begin
      half_s = data_i[31:16];
    end else begin
      half_s = data_i[15:0];
    end

    case (fun_i)
      FUNC_LB:  value_o = {{24{byte_s[7]}}, byte_s};
      FUNC_LH:  value_o = {{16{half_s[15]}}, half_s};
      FUNC_LBU: value_o = {24'h000000, byte_s};
      FUNC_LHU: value_o = {16'h0000, half_s};
      default:  value_o = data_i;
    endcase
  end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback stage: picks the rd value (ALU, divider or aligned load data),
// drives the register-file write port and stalls while a load is outstanding.
module urv_writeback
  import urv_writeback_pkg::*;
#(
  parameter int g_load_timeout = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  urv_writeback_if.slave  wb
);

  localparam int CW = (g_load_timeout > 1) ? $clog2(g_load_timeout) : 1;

  wb_state_t   state_q;
  logic [4:0]  ld_rd_q;
  logic        ld_write_q;
  logic [2:0]  ld_fun_q;
  logic [1:0]  ld_addr_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]  rf_rd_q;
  logic [31:0] rf_value_q;
  logic        rf_write_q;

  logic        capture_s;
  logic        timeout_s;
  logic [31:0] sel_value_s;
  logic [31:0] load_value_s;

  urv_load_align u_align (
    .fun_i   (ld_fun_q),
    .addr_i  (ld_addr_q),
    .data_i  (wb.dm_data_l_i),
    .value_o (load_value_s)
  );

  // Capture qualification, ALU/DIV select and timeout detection (done has priority).
  always_comb begin
    capture_s = (state_q == WB_IDLE) && wb.x_valid_i && !wb.x_stall_i;

    if (wb.x_rd_source_i == RD_SOURCE_DIV) begin
      sel_value_s = wb.x_div_result_i;
    end else begin
      sel_value_s = wb.x_rd_value_i;
    end

    if ((g_load_timeout > 0) && (state_q == WB_WAIT_LOAD) && !wb.dm_load_done_i) begin
      timeout_s = (cnt_q == CW'(g_load_timeout - 1));
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Writeback FSM with registered register-file port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= WB_IDLE;
      ld_rd_q    <= 5'd0;
      ld_write_q <= 1'b0;
      ld_fun_q   <= 3'd0;
      ld_addr_q  <= 2'd0;
      cnt_q      <= '0;
      rf_rd_q    <= 5'd0;
      rf_value_q <= 32'd0;
      rf_write_q <= 1'b0;
    end else begin
      rf_write_q <= 1'b0;
      case (state_q)
        WB_IDLE: begin
          if (capture_s) begin
            if (wb.x_rd_source_i == RD_SOURCE_LOAD) begin
              state_q    <= WB_WAIT_LOAD;
              ld_rd_q    <= wb.x_rd_i;
              ld_write_q <= wb.x_rd_write_i;
              ld_fun_q   <= wb.x_load_fun_i;
              ld_addr_q  <= wb.x_dm_addr_i;
              cnt_q      <= '0;
            end else begin
              rf_rd_q    <= wb.x_rd_i;
              rf_value_q <= sel_value_s;
              rf_write_q <= wb.x_rd_write_i && (wb.x_rd_i != 5'd0);
            end
          end
        end
        WB_WAIT_LOAD: begin
          if (wb.dm_load_done_i) begin
            state_q    <= WB_IDLE;
            rf_rd_q    <= ld_rd_q;
            rf_value_q <= load_value_s;
            rf_write_q <= ld_write_q && (ld_rd_q != 5'd0);
          end else if (timeout_s) begin
            state_q <= WB_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  assign wb.rf_rd_o          = rf_rd_q;
  assign wb.rf_rd_value_o    = rf_value_q;
  assign wb.rf_rd_write_o    = rf_write_q;
  assign wb.w_load_timeout_o = timeout_s;
  assign wb.w_stall_req_o    = (state_q == WB_WAIT_LOAD) && !wb.dm_load_done_i && !timeout_s;

endmodule

// File: tb/tb_urv_writeback.sv
// Self-checking bench for urv_writeback: directed vector table, hand-written
// multi-cycle sequences and randomized instructions against a reference model.
module tb_urv_writeback;

  localparam int T = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  urv_writeback_if bus ();

  urv_writeback #(.g_load_timeout(T)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic [4:0]  rd;
    logic        wr;
    logic [2:0]  fun;
    logic [1:0]  addr;
    logic [31:0] val;
    logic [31:0] div;
    logic [31:0] data;
    int          delay;
    logic        exp_wr;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load extraction using shifts and two's-complement arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] fun, input logic [1:0] addr,
                                           input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * int'(addr))) & 32'h0000_00FF;
    h = (d >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
    case (fun)
      3'b000:  return (b >= 32'h80) ? b - 32'h100 : b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h1_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  // Issue one instruction; for loads, run the wait phase (done in WAIT cycle delay+1).
  task automatic run_one(input logic [1:0] src, input logic [4:0] rd, input logic wr,
                         input logic [2:0] fun, input logic [1:0] addr, input logic [31:0] val,
                         input logic [31:0] div, input logic [31:0] data, input int delay,
                         input logic exp_wr, input logic [31:0] exp_val);
    int  end_c;
    int  stalls;
    int  tos;
    bit  timed_out;
    timed_out = (delay + 1 > T);
    bus.x_valid_i      = 1'b1;
    bus.x_stall_i      = 1'b0;
    bus.x_rd_i         = rd;
    bus.x_rd_write_i   = wr;
    bus.x_rd_source_i  = src;
    bus.x_rd_value_i   = val;
    bus.x_div_result_i = div;
    bus.x_load_fun_i   = fun;
    bus.x_dm_addr_i    = addr;
    bus.dm_load_done_i = 1'($urandom_range(0, 1));
    bus.dm_data_l_i    = $urandom;
    @(posedge clk); #1;
    bus.x_valid_i      = 1'b0;
    bus.x_div_result_i = $urandom;
    bus.dm_load_done_i = 1'b0;
    if (src == 2'd2) begin
      end_c  = timed_out ? T : delay + 1;
      stalls = 0;
      tos    = 0;
      for (int c = 1; c <= end_c; c++) begin
        bus.dm_data_l_i    = (c == delay + 1) ? data : $urandom;
        bus.dm_load_done_i = (c == delay + 1);
        @(negedge clk);
        if (bus.w_stall_req_o) stalls++;
        if (bus.w_load_timeout_o) tos++;
        @(posedge clk); #1;
      end
      bus.dm_load_done_i = 1'b0;
      chk("stall_cycles", 32'(stalls), 32'(end_c - 1));
      chk("timeout_pulses", 32'(tos), timed_out ? 32'd1 : 32'd0);
    end
    chk("rf_write", {31'd0, bus.rf_rd_write_o}, {31'd0, exp_wr});
    if (exp_wr) begin
      chk("rf_rd", {27'd0, bus.rf_rd_o}, {27'd0, rd});
      chk("rf_value", bus.rf_rd_value_o, exp_val);
    end
  endtask

  initial begin
    logic [1:0]  r_src;
    logic [4:0]  r_rd;
    logic        r_wr;
    logic [2:0]  r_fun;
    logic [1:0]  r_addr;
    logic [31:0] r_val;
    logic [31:0] r_div;
    logic [31:0] r_data;
    int          r_delay;
    logic [31:0] m_val;
    logic        m_wr;

    vecs = '{
      '{2'd0, 5'd5,  1'b1, 3'b000, 2'd0, 32'h1234_5678, 32'h0,         32'h0,         0,  1'b1, 32'h1234_5678},
      '{2'd1, 5'd7,  1'b1, 3'b000, 2'd0, 32'h0000_0055, 32'hFFFF_FFFF, 32'h0,         0,  1'b1, 32'hFFFF_FFFF},
      '{2'd1, 5'd0,  1'b1, 3'b000, 2'd0, 32'h0000_0055, 32'hFFFF_FFFF, 32'h0,         0,  1'b0, 32'h0},
      '{2'd2, 5'd8,  1'b1, 3'b000, 2'd3, 32'h0,         32'h0,         32'h80F1_7F02, 2,  1'b1, 32'hFFFF_FF80},
      '{2'd2, 5'd8,  1'b1, 3'b100, 2'd3, 32'h0,         32'h0,         32'h80F1_7F02, 2,  1'b1, 32'h0000_0080},
      '{2'd2, 5'd8,  1'b1, 3'b001, 2'd2, 32'h0,         32'h0,         32'h80F1_7F02, 2,  1'b1, 32'hFFFF_80F1},
      '{2'd2, 5'd8,  1'b1, 3'b101, 2'd0, 32'h0,         32'h0,         32'h80F1_7F02, 2,  1'b1, 32'h0000_7F02},
      '{2'd2, 5'd8,  1'b1, 3'b010, 2'd1, 32'h0,         32'h0,         32'h80F1_7F02, 2,  1'b1, 32'h80F1_7F02},
      '{2'd2, 5'd8,  1'b1, 3'b001, 2'd3, 32'h0,         32'h0,         32'h80F1_7F02, 1,  1'b1, 32'hFFFF_80F1},
      '{2'd3, 5'd9,  1'b1, 3'b000, 2'd0, 32'hCAFE_F00D, 32'h1,         32'h0,         0,  1'b1, 32'hCAFE_F00D},
      '{2'd0, 5'd10, 1'b0, 3'b000, 2'd0, 32'h1111_1111, 32'h0,         32'h0,         0,  1'b0, 32'h0},
      '{2'd2, 5'd14, 1'b1, 3'b011, 2'd2, 32'h0,         32'h0,         32'h80F1_7F02, 3,  1'b1, 32'h80F1_7F02},
      '{2'd2, 5'd0,  1'b1, 3'b010, 2'd0, 32'h0,         32'h0,         32'h80F1_7F02, 2,  1'b0, 32'h0},
      '{2'd2, 5'd11, 1'b1, 3'b000, 2'd0, 32'h0,         32'h0,         32'h80F1_7F02, 4,  1'b1, 32'h0000_0002},
      '{2'd2, 5'd12, 1'b1, 3'b010, 2'd0, 32'h0,         32'h0,         32'h80F1_7F02, 20, 1'b0, 32'h0},
      '{2'd2, 5'd13, 1'b1, 3'b100, 2'd1, 32'h0,         32'h0,         32'h80F1_7F02, 7,  1'b1, 32'h0000_007F},
      '{2'd2, 5'd15, 1'b1, 3'b101, 2'd2, 32'h0,         32'h0,         32'h80F1_7F02, 0,  1'b1, 32'h0000_80F1}
    };

    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.x_valid_i = 1'b0; bus.x_stall_i = 1'b0; bus.x_rd_i = 5'd0; bus.x_rd_write_i = 1'b0;
    bus.x_rd_source_i = 2'd0; bus.x_rd_value_i = 32'd0; bus.x_div_result_i = 32'd0;
    bus.x_load_fun_i = 3'd0; bus.x_dm_addr_i = 2'd0; bus.dm_data_l_i = 32'd0;
    bus.dm_load_done_i = 1'b0;
    #2;
    chk("reset_write", {31'd0, bus.rf_rd_write_o}, 32'd0);
    chk("reset_rd", {27'd0, bus.rf_rd_o}, 32'd0);
    chk("reset_value", bus.rf_rd_value_o, 32'd0);
    chk("reset_stall", {31'd0, bus.w_stall_req_o}, 32'd0);
    chk("reset_timeout", {31'd0, bus.w_load_timeout_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_one(vecs[i].src, vecs[i].rd, vecs[i].wr, vecs[i].fun, vecs[i].addr, vecs[i].val,
              vecs[i].div, vecs[i].data, vecs[i].delay, vecs[i].exp_wr, vecs[i].exp_val);
    end

    // Back-to-back ALU instructions right after a load retire one per cycle.
    run_one(2'd2, 5'd3, 1'b1, 3'b010, 2'd0, 32'h0, 32'h0, 32'h0BAD_BEEF, 4, 1'b1, 32'h0BAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      bus.x_valid_i     = 1'b1;
      bus.x_stall_i     = 1'b0;
      bus.x_rd_source_i = 2'd0;
      bus.x_rd_i        = 5'(k + 1);
      bus.x_rd_write_i  = 1'b1;
      bus.x_rd_value_i  = 32'hA000_0000 + 32'(k);
      @(posedge clk); #1;
      chk("b2b_write", {31'd0, bus.rf_rd_write_o}, 32'd1);
      chk("b2b_rd", {27'd0, bus.rf_rd_o}, 32'(k + 1));
      chk("b2b_value", bus.rf_rd_value_o, 32'hA000_0000 + 32'(k));
    end
    bus.x_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("write_pulse", {31'd0, bus.rf_rd_write_o}, 32'd0);

    // Global stall blocks capture.
    bus.x_valid_i = 1'b1; bus.x_stall_i = 1'b1; bus.x_rd_i = 5'd6; bus.x_rd_write_i = 1'b1;
    @(posedge clk); #1;
    bus.x_valid_i = 1'b0; bus.x_stall_i = 1'b0;
    chk("stall_no_capture", {31'd0, bus.rf_rd_write_o}, 32'd0);

    // Capture attempts during WAIT_LOAD are ignored.
    bus.x_valid_i = 1'b1; bus.x_rd_source_i = 2'd2; bus.x_rd_i = 5'd3; bus.x_rd_write_i = 1'b1;
    bus.x_load_fun_i = 3'b010; bus.x_dm_addr_i = 2'd0;
    @(posedge clk); #1;
    bus.x_rd_source_i = 2'd0; bus.x_rd_i = 5'd9; bus.x_rd_value_i = 32'h0000_0999;
    @(posedge clk); #1;
    bus.dm_load_done_i = 1'b1; bus.dm_data_l_i = 32'h1357_9BDF;
    @(posedge clk); #1;
    bus.dm_load_done_i = 1'b0; bus.x_valid_i = 1'b0;
    chk("wait_ign_write", {31'd0, bus.rf_rd_write_o}, 32'd1);
    chk("wait_ign_rd", {27'd0, bus.rf_rd_o}, 32'd3);
    chk("wait_ign_value", bus.rf_rd_value_o, 32'h1357_9BDF);
    @(posedge clk); #1;
    chk("wait_ign_after", {31'd0, bus.rf_rd_write_o}, 32'd0);

    // Randomized instructions against the reference model.
    for (int n = 0; n < 150; n++) begin
      r_src   = 2'($urandom_range(0, 3));
      r_rd    = 5'($urandom_range(0, 31));
      r_wr    = 1'($urandom_range(0, 1));
      r_fun   = 3'($urandom_range(0, 7));
      r_addr  = 2'($urandom_range(0, 3));
      r_val   = $urandom;
      r_div   = $urandom;
      r_data  = $urandom;
      r_delay = $urandom_range(0, 10);
      if (r_src == 2'd1) m_val = r_div;
      else if (r_src == 2'd2) m_val = ref_load(r_fun, r_addr, r_data);
      else m_val = r_val;
      m_wr = r_wr && (r_rd != 5'd0) && !((r_src == 2'd2) && (r_delay + 1 > T));
      run_one(r_src, r_rd, r_wr, r_fun, r_addr, r_val, r_div, r_data, r_delay, m_wr, m_val);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("rand_idle", {31'd0, bus.rf_rd_write_o}, 32'd0);
      end
    end

    // Async reset between edges while a load is pending.
    run_one(2'd0, 5'd21, 1'b1, 3'b000, 2'd0, 32'h7777_7777, 32'h0, 32'h0, 0, 1'b1, 32'h7777_7777);
    bus.x_valid_i = 1'b1; bus.x_rd_source_i = 2'd2; bus.x_rd_i = 5'd4; bus.x_rd_write_i = 1'b1;
    bus.x_load_fun_i = 3'b010;
    @(posedge clk); #1;
    bus.x_valid_i = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_stall", {31'd0, bus.w_stall_req_o}, 32'd0);
    chk("arst_write", {31'd0, bus.rf_rd_write_o}, 32'd0);
    chk("arst_rd", {27'd0, bus.rf_rd_o}, 32'd0);
    chk("arst_value", bus.rf_rd_value_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.dm_load_done_i = 1'b1; bus.dm_data_l_i = 32'h2468_ACE0;
    @(posedge clk); #1;
    bus.dm_load_done_i = 1'b0;
    chk("arst_done_nowrite", {31'd0, bus.rf_rd_write_o}, 32'd0);
    @(posedge clk); #1;
    chk("arst_done_nowrite2", {31'd0, bus.rf_rd_write_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
